// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// Exactly one transaction is in flight. Data has priority, but a pending fetch is forced through after MAX_WAIT data issues.
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [1:0]          state_dbg
);
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] starve_cnt;
  logic             fetch_win, data_win;

  // Handshake: a requester holds req and payload until its gnt. A gnt is given only in IDLE when mem_ready
  // accepts mem_req. The single response then comes back on the owner's rvalid, as a pass-through of mem_rvalid.
  always_comb begin
    fetch_win = if_req && (!d_req || starve_cnt == CNT_MAX);
    data_win  = d_req && !fetch_win;
  end

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    if_rdata  = '0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    if (!reset) begin
      unique case (state)
        IDLE: begin
          if (fetch_win) begin
            mem_req  = 1'b1;
            mem_addr = if_addr;
            mem_be   = '1;
          end else if (data_win) begin
            mem_req   = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_be    = d_be;
          end
          if (mem_req && mem_ready) begin
            if_gnt    = fetch_win;
            d_gnt     = data_win;
            state_nxt = fetch_win ? WAIT_I : WAIT_D;
          end
        end
        WAIT_I: begin
          if (mem_rvalid) begin
            if_rvalid = 1'b1;
            if_rdata  = mem_rdata;
            state_nxt = IDLE;
          end
        end
        WAIT_D: begin
          if (mem_rvalid) begin
            d_rvalid  = 1'b1;
            d_rdata   = mem_rdata;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // The starvation count only advances while a fetch is actually waiting behind a data issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (if_gnt) begin
        starve_cnt <= '0;
      end else if (d_gnt && if_req && starve_cnt != CNT_MAX) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a memory model with a reference array, an arbitration model driven by the priority and
// starvation rules, and response scoreboards. Directed scenarios are followed by a randomized phase.
module tb_mem_arbiter;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int BE_W     = DATA_W / 8;
  localparam int MAX_WAIT = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt, if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req, d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [BE_W-1:0]   d_be;
  logic              d_gnt, d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic              mem_ready, mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic [1:0]        state_dbg;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .state_dbg(state_dbg)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Scoreboard state
  logic [DATA_W-1:0] if_exp_q[$];
  logic [DATA_W-1:0] d_exp_q[$];
  logic [DATA_W-1:0] mem_arr[0:15];
  byte               grant_log[$];
  int                n_checks = 0;
  int                n_pass   = 0;

  // Reference model and memory model state
  logic              m_busy = 1'b0;
  logic              m_owner_i = 1'b0;
  int                m_starve = 0;
  int                mem_cnt = 0;
  logic [DATA_W-1:0] mem_data = '0;
  int                lat_cfg = 1;
  logic              rand_lat = 1'b0;
  logic              spurious_en = 1'b0;
  logic              if_taken = 1'b0;
  logic              d_taken = 1'b0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: checks every cycle against the rule-based model, then advances the model.
  always @(negedge clk) begin
    logic exp_i, exp_d, exp_req;
    int   idx;
    if (reset) begin
      check("reset_ctrl_outputs", {if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we, mem_be}, '0);
      check("reset_data_outputs", if_rdata | d_rdata | mem_addr | mem_wdata, '0);
      m_busy   = 1'b0;
      m_starve = 0;
      if_exp_q.delete();
      d_exp_q.delete();
      if_taken = 1'b0;
      d_taken  = 1'b0;
    end else begin
      exp_i   = !m_busy && if_req && (!d_req || m_starve == MAX_WAIT);
      exp_d   = !m_busy && d_req && !exp_i;
      exp_req = exp_i || exp_d;
      check("mem_req", mem_req, exp_req);
      check("if_gnt", if_gnt, exp_i && mem_ready);
      check("d_gnt", d_gnt, exp_d && mem_ready);
      if (exp_i)
        check("fetch_payload", {mem_we, mem_addr, mem_wdata, mem_be},
              {1'b0, if_addr, {DATA_W{1'b0}}, {BE_W{1'b1}}});
      else if (exp_d)
        check("data_payload", {mem_we, mem_addr, mem_wdata, mem_be}, {d_we, d_addr, d_wdata, d_be});
      else
        check("idle_payload", {mem_we, mem_addr, mem_wdata, mem_be}, '0);

      check("if_rvalid", if_rvalid, mem_rvalid && m_busy && m_owner_i);
      check("d_rvalid", d_rvalid, mem_rvalid && m_busy && !m_owner_i);
      if (if_rvalid && if_exp_q.size() > 0) check("if_rdata", if_rdata, if_exp_q.pop_front());
      else if (!if_rvalid) check("if_rdata_zero", if_rdata, '0);
      if (d_rvalid && d_exp_q.size() > 0) check("d_rdata", d_rdata, d_exp_q.pop_front());
      else if (!d_rvalid) check("d_rdata_zero", d_rdata, '0);

      if (mem_rvalid && m_busy) m_busy = 1'b0;
      if_taken = exp_i && mem_ready;
      d_taken  = exp_d && mem_ready;
      if (exp_req && mem_ready) begin
        m_busy    = 1'b1;
        m_owner_i = exp_i;
        if (exp_i) begin
          m_starve = 0;
          idx      = int'(if_addr[5:2]);
          mem_data = mem_arr[idx];
          if_exp_q.push_back(mem_data);
          grant_log.push_back("I");
        end else begin
          if (if_req && m_starve < MAX_WAIT) m_starve++;
          idx = int'(d_addr[5:2]);
          if (d_we) begin
            for (int b = 0; b < BE_W; b++)
              if (d_be[b]) mem_arr[idx][8*b +: 8] = d_wdata[8*b +: 8];
            mem_data = '0;
          end else begin
            mem_data = mem_arr[idx];
          end
          d_exp_q.push_back(mem_data);
          grant_log.push_back("D");
        end
        mem_cnt = rand_lat ? int'($urandom_range(1, 4)) : lat_cfg;
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem_data;
      end
    end else if (spurious_en && $urandom_range(0, 7) == 0) begin
      mem_rvalid = 1'b1;
      mem_rdata  = $urandom;
    end
  endtask

  task automatic drop_taken();
    if (if_taken) if_req = 1'b0;
    if (d_taken) d_req = 1'b0;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      drop_taken();
    end
  endtask

  task automatic rand_reqs();
    if (!if_req || if_taken) begin
      if_req  = ($urandom_range(0, 2) != 0);
      if_addr = $urandom & 32'h0000_fffc;
    end
    if (!d_req || d_taken) begin
      d_req   = ($urandom_range(0, 2) != 0);
      d_we    = 1'($urandom_range(0, 1));
      d_addr  = $urandom & 32'h0000_fffc;
      d_wdata = $urandom;
      d_be    = BE_W'($urandom_range(1, 15));
    end
    mem_ready = ($urandom_range(0, 3) != 0);
  endtask

  byte exp_order[10] = '{"D", "D", "D", "D", "I", "D", "D", "D", "D", "I"};

  initial begin
    for (int i = 0; i < 16; i++) mem_arr[i] = $urandom;
    reset = 1'b1; if_req = 1'b1; if_addr = 32'h3000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h24; d_wdata = '0; d_be = 4'hf;
    mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;

    // Reset with both requests pending, then data wins the first IDLE cycle
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_d_gnt", d_gnt, 1);
    check("post_reset_mem_addr", mem_addr, 32'h24);
    tick(); drop_taken();
    check("post_reset_state", state_dbg, 2'd2);
    settle(8);

    // Single fetch with latency 3
    mem_arr[0] = 32'h2408_0001; lat_cfg = 3; if_addr = 32'h3000; if_req = 1'b1;
    @(negedge clk);
    check("fetch_gnt", if_gnt, 1);
    for (int k = 1; k <= 3; k++) begin
      tick(); drop_taken();
      @(negedge clk);
      check("fetch_rvalid_timing", if_rvalid, k == 3);
    end
    check("fetch_rdata", if_rdata, 32'h2408_0001);
    settle(2);

    // Store acknowledged on the data port
    lat_cfg = 2; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF; d_be = 4'hf;
    @(negedge clk);
    check("store_mem_we", mem_we, 1);
    check("store_payload", {mem_addr, mem_wdata, mem_be}, {32'h10, 32'hDEAD_BEEF, 4'hf});
    check("store_d_gnt", d_gnt, 1);
    tick(); drop_taken(); tick();
    @(negedge clk);
    check("store_ack", {d_rvalid, if_rvalid}, 2'b10);
    settle(2);
    d_we = 1'b0;

    // Starvation: both ports requesting continuously
    lat_cfg = 1; grant_log.delete(); if_req = 1'b1; d_req = 1'b1;
    for (int c = 0; c < 100 && grant_log.size() < 10; c++) begin
      tick();
      if (if_taken) if_addr = $urandom & 32'h0000_fffc;
      if (d_taken) d_addr = $urandom & 32'h0000_fffc;
    end
    check("starve_grants_seen", grant_log.size() >= 10, 1);
    for (int i = 0; i < 10 && i < grant_log.size(); i++)
      check($sformatf("starve_order_%0d", i), grant_log[i], exp_order[i]);
    settle(20);

    // Backpressure: request held with mem_ready low
    mem_ready = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h28;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_no_gnt", {if_gnt, d_gnt}, 2'b00);
      check("bp_hold", {mem_req, mem_addr}, {1'b1, 32'h28});
      tick();
    end
    mem_ready = 1'b1;
    @(negedge clk);
    check("bp_release_gnt", d_gnt, 1);
    settle(4);

    // Spurious response in IDLE
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    check("spurious_ignored", {if_rvalid, d_rvalid, if_rdata, d_rdata}, '0);

    // Reset while a fetch is outstanding; the late response must be dropped
    lat_cfg = 3; if_req = 1'b1; if_addr = 32'h3004;
    tick(); drop_taken();
    check("midflight_state", state_dbg, 2'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    @(negedge clk);
    check("stale_resp_ignored", {if_rvalid, if_rdata}, '0);
    settle(3);

    // Randomized traffic
    rand_lat = 1'b1; spurious_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      rand_reqs();
    end
    spurious_en = 1'b0; mem_ready = 1'b1;
    settle(30);
    check("scoreboard_drained", if_exp_q.size() + d_exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares one single-port memory between the instruction-fetch path (PC → instruction read) and the data path (ALU address → load/store) of the MIPS core. It enables a unified instruction/data memory. Each requester issues through a request/grant handshake, and the arbiter keeps exactly one memory transaction outstanding. The data port has priority, with a starvation limit that guarantees forward progress for instruction fetch.

## Interface
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- MAX_WAIT, 4, consecutive data issues tolerated while a fetch is pending before fetch is forced (≥1)

- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch accepted by memory this cycle
- if_rvalid  out  1  fetch response valid
- if_rdata  out  DATA_W  fetch read data
- d_req  in  1  data request; held with payload until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_be  in  DATA_W/8  store byte enables
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid, or store acknowledged
- d_rdata  out  DATA_W  load data
- mem_req, mem_we, mem_addr, mem_wdata, mem_be  out  1/1/ADDR_W/DATA_W/DATA_W/8  memory request and payload
- mem_ready  in  1  memory accepts mem_req this cycle
- mem_rvalid  in  1  one response per accepted request, including stores
- mem_rdata  in  DATA_W  response data

## Operation
- States: IDLE, WAIT_I, WAIT_D. Starvation counter starve_cnt has width $clog2(MAX_WAIT+1) and saturates at MAX_WAIT.
- **IDLE, winner selection:**
  - Fetch wins if if_req and (!d_req or starve_cnt == MAX_WAIT).
  - Otherwise data wins if d_req.
  - Otherwise there is no winner.
- **IDLE, request drive:** mem_req = 1 when a winner exists. mem_* carries the winner's payload combinationally. For a fetch: mem_we = 0, mem_be = all ones, mem_wdata = 0.
- **IDLE, issue:** an issue occurs when mem_req && mem_ready.
  - The winner's gnt is asserted in the same cycle.
  - The next state is WAIT_I or WAIT_D.
  - If mem_ready = 0, no gnt is given. Arbitration is re-evaluated next cycle, and the winner may change.
- **starve_cnt update:**
  - Cleared on a fetch issue.
  - Incremented, saturating, on a data issue while if_req = 1.
  - Otherwise held.
- **WAIT_I / WAIT_D:**
  - mem_req = 0 and both gnt outputs are 0.
  - On mem_rvalid, the owner's rvalid is asserted with rdata = mem_rdata, and the next state is IDLE.
  - The non-owner rvalid stays 0.
- mem_rvalid in IDLE is spurious and is ignored. No rvalid is produced.
- if_rdata and d_rdata are 0 whenever their rvalid is 0.
- mem_* payload outputs are 0 whenever mem_req = 0.
- The requester contract (hold req and payload stable until gnt) is an input assumption. The arbiter does not latch the payload.

## Timing
- Reset (synchronous): state IDLE, starve_cnt 0. In the cycle reset is high, all outputs are 0: gnt, rvalid, rdata, mem_req, and mem payload.
- Reset mid-transaction abandons the transaction. The memory shares this reset, and any later response is ignored in IDLE.
- Request → gnt: 0 cycles (combinational) when in IDLE with mem_ready = 1.
- gnt → rvalid: equals the memory latency, ≥1 cycle. rvalid is a combinational pass-through of mem_rvalid.
- After a response the arbiter returns to IDLE and can issue in the following cycle. Minimum spacing is 2 cycles per transaction.
- Simultaneous if_req and d_req: data wins unless starve_cnt == MAX_WAIT.
- The arbiter never produces two gnts in one cycle, and never more than one outstanding transaction.

## Test plan
- **Reset:** assert reset with if_req = d_req = 1 and mem_ready = 1. All outputs must be 0. Release reset, then on the first IDLE cycle expect d_gnt = 1, mem_addr = d_addr, and state WAIT_D.
- **Single fetch:** if_addr = 0x3000, memory latency 3, rdata 0x24080001. Expect if_gnt in cycle 0, if_rvalid with if_rdata = 0x24080001 in cycle 3, and d_rvalid = 0 throughout.
- **Store ack:** d_we = 1, d_addr = 0x10, d_wdata = 0xDEADBEEF, d_be = 0xF. Expect mem_we = 1 with that payload, then d_rvalid = 1 on the response and if_rvalid = 0.
- **Starvation:** with MAX_WAIT = 4, hold if_req and d_req continuously. Expect the grant order D, D, D, D, I, D, D, D, D, I.
- **Backpressure:** hold mem_ready = 0 for 5 cycles with d_req = 1. Expect no gnt and stable mem_req/mem_addr. Then raise mem_ready and expect d_gnt in that same cycle.
- **Spurious/reset mid-flight:** a mem_rvalid pulse in IDLE gives no rvalid. Reset while in WAIT_I, then deliver mem_rvalid: expect if_rvalid = 0.
